scan_sel_sequencer: RTL and testbench

//  Upstream driver for the 3-to-8 decoder. Steps a registered 3-bit select through
//  the enabled channels of an 8-bit mask and holds each channel for a programmable

---
 rtl/scan_sel_if.sv | 26 ++
 rtl/scan_sel_sequencer.sv | 178 +++++++++++++++++
 tb/tb_scan_sel_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_sel_if.sv
// Bundles the control inputs and decoder-facing outputs of the scan select sequencer.
// The master side (controller or bench) drives the controls; the slave side is the sequencer.
interface scan_sel_if #(
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             stop;
    logic             mode_cont;
    logic [7:0]       ch_mask;
    logic [CNT_W-1:0] dwell;
    logic [2:0]       sel;
    logic             sel_en;
    logic             busy;
    logic             frame_done;
    logic             err_mask;

    modport master (
        output start, stop, mode_cont, ch_mask, dwell,
        input  sel, sel_en, busy, frame_done, err_mask
    );

    modport slave (
        input  start, stop, mode_cont, ch_mask, dwell,
        output sel, sel_en, busy, frame_done, err_mask
    );
endinterface

// File: rtl/scan_sel_sequencer.sv
// Scan select sequencer: walks a registered 3-bit select through the enabled
// channels of a latched mask, holding each channel for a dwell time with a
// blanking gap (decoder disabled) in front of every dwell. All outputs are registered.
module scan_sel_sequencer #(
    parameter int CNT_W        = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    scan_sel_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

    // Blank counter holds BLANK_CYCLES-1 down to 0; keep at least one bit.
    localparam int BW = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t           state, state_nxt;
    logic [2:0]       sel, sel_nxt;
    logic             sel_en, sel_en_nxt;
    logic             busy, busy_nxt;
    logic             frame_done, frame_done_nxt;
    logic             err_mask, err_mask_nxt;
    logic [7:0]       mask_lat, mask_lat_nxt;
    logic [CNT_W-1:0] dwell_lat, dwell_lat_nxt;
    logic             cont_lat, cont_lat_nxt;
    logic [BW-1:0]    bcnt, bcnt_nxt;
    logic [CNT_W-1:0] dcnt, dcnt_nxt;

    logic             enter;
    logic [2:0]       enter_ch;
    logic [CNT_W-1:0] enter_dw;
    logic [3:0]       hit;

    // Lowest set bit of m at or above index 'from'; returns {found, index}.
    function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // Dwell counter start value; a dwell of zero is stretched to one cycle.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    assign bus.sel        = sel;
    assign bus.sel_en     = sel_en;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.err_mask   = err_mask;

    // Next-state and next-output logic; 'enter' funnels every channel entry
    // (frame start, channel advance, wrap) through one place.
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        sel_en_nxt     = sel_en;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;
        err_mask_nxt   = 1'b0;
        mask_lat_nxt   = mask_lat;
        dwell_lat_nxt  = dwell_lat;
        cont_lat_nxt   = cont_lat;
        bcnt_nxt       = bcnt;
        dcnt_nxt       = dcnt;
        enter          = 1'b0;
        enter_ch       = sel;
        enter_dw       = dwell_lat;
        hit            = '0;

        if (bus.stop) begin
            state_nxt  = IDLE;
            sel_en_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.ch_mask == 8'h00) begin
                            err_mask_nxt = 1'b1;
                        end else begin
                            mask_lat_nxt  = bus.ch_mask;
                            dwell_lat_nxt = bus.dwell;
                            cont_lat_nxt  = bus.mode_cont;
                            hit           = find_ch(bus.ch_mask, 4'd0);
                            enter         = 1'b1;
                            enter_ch      = hit[2:0];
                            enter_dw      = bus.dwell;
                        end
                    end
                end
                BLANK: begin
                    if (bcnt == '0) begin
                        state_nxt  = DWELL;
                        sel_en_nxt = 1'b1;
                        dcnt_nxt   = dwell_load(dwell_lat);
                    end else begin
                        bcnt_nxt = bcnt - BW'(1);
                    end
                end
                DWELL: begin
                    if (dcnt == '0) begin
                        hit = find_ch(mask_lat, {1'b0, sel} + 4'd1);
                        if (hit[3]) begin
                            enter    = 1'b1;
                            enter_ch = hit[2:0];
                        end else begin
                            frame_done_nxt = 1'b1;
                            if (cont_lat) begin
                                hit      = find_ch(mask_lat, 4'd0);
                                enter    = 1'b1;
                                enter_ch = hit[2:0];
                            end else begin
                                state_nxt  = IDLE;
                                sel_en_nxt = 1'b0;
                                busy_nxt   = 1'b0;
                            end
                        end
                    end else begin
                        dcnt_nxt = dcnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    sel_en_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
            endcase
        end

        if (enter) begin
            sel_nxt  = enter_ch;
            busy_nxt = 1'b1;
            if (BLANK_CYCLES == 0) begin
                state_nxt  = DWELL;
                sel_en_nxt = 1'b1;
                dcnt_nxt   = dwell_load(enter_dw);
            end else begin
                state_nxt  = BLANK;
                sel_en_nxt = 1'b0;
                bcnt_nxt   = BLANK_LOAD;
            end
        end
    end

    // State, output and latched-configuration registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            sel_en     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_mask   <= 1'b0;
            mask_lat   <= '0;
            dwell_lat  <= '0;
            cont_lat   <= 1'b0;
            bcnt       <= '0;
            dcnt       <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            sel_en     <= sel_en_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
            err_mask   <= err_mask_nxt;
            mask_lat   <= mask_lat_nxt;
            dwell_lat  <= dwell_lat_nxt;
            cont_lat   <= cont_lat_nxt;
            bcnt       <= bcnt_nxt;
            dcnt       <= dcnt_nxt;
        end
    end
endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Bench for scan_sel_sequencer: a frame-level model expands mask/dwell/mode
// into the expected per-cycle {sel, sel_en, busy, frame_done, err_mask} trace.
module tb_scan_sel_sequencer;
    localparam int CNT_W = 16;
    localparam int BLANK = 2;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    scan_sel_if #(.CNT_W(CNT_W)) bus ();

    scan_sel_sequencer #(.CNT_W(CNT_W), .BLANK_CYCLES(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t exp_q[$];
    bit   pend_done;
    logic [2:0] last_sel;

    function automatic void push_obs(input logic [2:0] s, input logic en, input logic busy);
        obs_t o;
        o.sel  = s;
        o.en   = en;
        o.busy = busy;
        o.done = pend_done;
        o.err  = 1'b0;
        pend_done = 1'b0;
        exp_q.push_back(o);
    endfunction

    // Expected trace from the cycle after start: each enabled channel in
    // ascending order gets BLANK disabled cycles then max(dwell,1) enabled
    // cycles; frame_done marks the first cycle after each completed pass.
    function automatic void model_frames(input logic [7:0] m, input int d,
                                         input bit cont, input int passes);
        int dw;
        logic [2:0] last;
        dw = (d == 0) ? 1 : d;
        last = '0;
        exp_q.delete();
        pend_done = 1'b0;
        for (int p = 0; p < passes; p++) begin
            for (int ch = 0; ch < 8; ch++) begin
                if (m[ch]) begin
                    for (int b = 0; b < BLANK; b++) push_obs(3'(ch), 1'b0, 1'b1);
                    for (int k = 0; k < dw; k++) push_obs(3'(ch), 1'b1, 1'b1);
                    last = 3'(ch);
                end
            end
            pend_done = 1'b1;
        end
        if (!cont) begin
            push_obs(last, 1'b0, 1'b0);
            push_obs(last, 1'b0, 1'b0);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] m, input int d, input bit cont);
        bus.ch_mask   = m;
        bus.dwell     = CNT_W'(d);
        bus.mode_cont = cont;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode_cont = 1'b0;
        bus.ch_mask = '0; bus.dwell = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
        n_checks++;
        if (got !== 7'b0) $display("FAIL reset outputs got %b exp %b", got, 7'b0);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
        n_checks++;
        if (got !== 7'b0) $display("FAIL reset_idle outputs got %b exp %b", got, 7'b0);
        else n_pass++;
    endtask

    task automatic test_single();
        obs_t got;
        logic [7:0] m;
        int d;
        for (int f = 0; f < 7; f++) begin
            m = (f == 0) ? 8'b0000_0101 : 8'($urandom_range(1, 255));
            d = (f == 0) ? 3 : $urandom_range(0, 4);
            model_frames(m, d, 1'b0, 1);
            launch(m, d, 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
                n_checks++;
                if (got !== exp_q[i])
                    $display("FAIL single f%0d m=%h d=%0d [%0d] got %b exp %b", f, m, d, i, got, exp_q[i]);
                else n_pass++;
                tick();
            end
            last_sel = exp_q[exp_q.size()-1].sel;
        end
    endtask

    task automatic test_continuous();
        obs_t got, e;
        logic [7:0] m;
        int d, s, plen;
        for (int f = 0; f < 4; f++) begin
            m = (f == 0) ? 8'h81 : 8'($urandom_range(1, 255));
            d = (f == 0) ? 1 : $urandom_range(0, 3);
            model_frames(m, d, 1'b1, 3);
            plen = exp_q.size() / 3;
            s = (f == 0) ? exp_q.size() - 1 : $urandom_range(plen, exp_q.size() - 1);
            launch(m, d, 1'b1);
            for (int i = 0; i <= s; i++) begin
                got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
                n_checks++;
                if (got !== exp_q[i])
                    $display("FAIL cont f%0d m=%h d=%0d [%0d] got %b exp %b", f, m, d, i, got, exp_q[i]);
                else n_pass++;
                if (i < s) tick();
            end
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            e = '{sel: exp_q[s].sel, en: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            for (int k = 0; k < 2; k++) begin
                got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
                n_checks++;
                if (got !== e) $display("FAIL stop f%0d +%0d got %b exp %b", f, k, got, e);
                else n_pass++;
                tick();
            end
            last_sel = exp_q[s].sel;
        end
    endtask

    task automatic test_zero_mask();
        obs_t got, e;
        bus.ch_mask = 8'h00;
        bus.dwell   = CNT_W'(2);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        e = '{sel: last_sel, en: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b1};
        got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
        n_checks++;
        if (got !== e) $display("FAIL zero_mask pulse got %b exp %b", got, e);
        else n_pass++;
        tick();
        e.err = 1'b0;
        got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
        n_checks++;
        if (got !== e) $display("FAIL zero_mask after got %b exp %b", got, e);
        else n_pass++;
    endtask

    task automatic test_edge();
        obs_t got, e;
        model_frames(8'h10, 0, 1'b0, 1);
        launch(8'h10, 0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL dwell0 [%0d] got %b exp %b", i, got, exp_q[i]);
            else n_pass++;
            tick();
        end
        bus.ch_mask = 8'h03;
        bus.dwell   = CNT_W'(2);
        bus.start   = 1'b1;
        bus.stop    = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        e = '{sel: 3'd4, en: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
        for (int k = 0; k < 4; k++) begin
            got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
            n_checks++;
            if (got !== e) $display("FAIL start_stop +%0d got %b exp %b", k, got, e);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_latching();
        obs_t got;
        model_frames(8'h06, 2, 1'b0, 1);
        launch(8'h06, 2, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 0) begin
                bus.ch_mask   = 8'hFF;
                bus.dwell     = CNT_W'(5);
                bus.mode_cont = 1'b1;
            end
            bus.start = (i == 3);
            got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL latch [%0d] got %b exp %b", i, got, exp_q[i]);
            else n_pass++;
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t got;
        model_frames(8'h0C, 4, 1'b0, 1);
        launch(8'h0C, 4, 1'b0);
        for (int i = 0; i < BLANK + 1; i++) begin
            got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL arst_pre [%0d] got %b exp %b", i, got, exp_q[i]);
            else n_pass++;
            if (i < BLANK) tick();
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
        n_checks++;
        if (got !== 7'b0) $display("FAIL arst_clear got %b exp %b", got, 7'b0);
        else n_pass++;
        #2 rst_n = 1'b1;
        tick();
        model_frames(8'h0C, 1, 1'b0, 1);
        launch(8'h0C, 1, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = {bus.sel, bus.sel_en, bus.busy, bus.frame_done, bus.err_mask};
            n_checks++;
            if (got !== exp_q[i]) $display("FAIL arst_post [%0d] got %b exp %b", i, got, exp_q[i]);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        last_sel = '0;
        test_reset();
        test_single();
        test_continuous();
        test_zero_mask();
        test_edge();
        test_latching();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_checks);
        $fatal(1);
    end
endmodule
